// File: rtl/fifo_pkg.sv
// Shared FIFO sizing defaults used by the write-side and read-side pointer blocks.
package fifo_pkg;

    localparam int FIFO_PTR_W     = 12;
    localparam int FIFO_AF_MARGIN = 4;
    localparam int FIFO_DEPTH     = 2 ** FIFO_PTR_W;

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary conversion; shared by the write-side full and read-side empty logic.
module gray_to_bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        o_bin = '0;
        for (int i = 0; i < W; i++) begin
            o_bin[i] = ^(i_gray >> i);
        end
    end

endmodule

// File: rtl/wr_ptr_full_ctrl.sv
// Write-domain pointer of an async FIFO: write address, Gray pointer export,
// conservative full/almost-full/level against the synchronized read pointer, sticky overflow.
module wr_ptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int PTR_W     = FIFO_PTR_W,
    parameter int AF_MARGIN = FIFO_AF_MARGIN
) (
    input  logic             i_wr_clk,
    input  logic             i_wr_rst,
    input  logic             i_wr_en,
    input  logic [PTR_W:0]   i_rd_ptr_sync,
    input  logic             i_ovf_clr,
    output logic             o_mem_we,
    output logic [PTR_W-1:0] o_wr_addr,
    output logic [PTR_W:0]   o_wr_ptr_gray,
    output logic             o_full,
    output logic             o_almost_full,
    output logic [PTR_W:0]   o_wr_level,
    output logic             o_overflow
);

    localparam int             DEPTH     = 2 ** PTR_W;
    localparam logic [PTR_W:0] AF_THRESH = (PTR_W + 1)'(DEPTH - AF_MARGIN);

    logic [PTR_W:0] r_wbin;
    logic [PTR_W:0] r_wr_ptr_gray;
    logic [PTR_W:0] r_wr_level;
    logic           r_full;
    logic           r_almost_full;
    logic           r_overflow;

    logic           w_wr_acc;
    logic [PTR_W:0] w_wbin_next;
    logic [PTR_W:0] w_gnext;
    logic [PTR_W:0] w_rbin;
    logic [PTR_W:0] w_full_gray;
    logic [PTR_W:0] w_level_next;

    // Gating with reset keeps the RAM untouched while the pointer is being cleared.
    assign w_wr_acc    = i_wr_en & ~r_full & ~i_wr_rst;
    assign w_wbin_next = r_wbin + {{PTR_W{1'b0}}, w_wr_acc};
    assign w_gnext     = w_wbin_next ^ (w_wbin_next >> 1);

    gray_to_bin #(
        .W (PTR_W + 1)
    ) u_rd_g2b (
        .i_gray (i_rd_ptr_sync),
        .o_bin  (w_rbin)
    );

    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    assign w_full_gray  = {~i_rd_ptr_sync[PTR_W:PTR_W-1], i_rd_ptr_sync[PTR_W-2:0]};
    assign w_level_next = w_wbin_next - w_rbin;

    always_ff @(posedge i_wr_clk or posedge i_wr_rst) begin
        if (i_wr_rst) begin
            r_wbin        <= '0;
            r_wr_ptr_gray <= '0;
            r_wr_level    <= '0;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_wbin        <= w_wbin_next;
            r_wr_ptr_gray <= w_gnext;
            r_wr_level    <= w_level_next;
            r_full        <= (w_gnext == w_full_gray);
            r_almost_full <= (w_level_next >= AF_THRESH);
            if (i_wr_en && r_full) begin
                r_overflow <= 1'b1;
            end else if (i_ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_mem_we      = w_wr_acc;
    assign o_wr_addr     = r_wbin[PTR_W-1:0];
    assign o_wr_ptr_gray = r_wr_ptr_gray;
    assign o_full        = r_full;
    assign o_almost_full = r_almost_full;
    assign o_wr_level    = r_wr_level;
    assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_wr_ptr_full_ctrl.sv
// Directed bench for wr_ptr_full_ctrl (PTR_W=4, AF_MARGIN=2) with a count-based reference model.
module tb_wr_ptr_full_ctrl;

    localparam int PW  = 4;
    localparam int AFM = 2;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          wr_en   = 1'b0;
    logic          ovf_clr = 1'b0;
    logic [PW:0]   rd_idx  = '0;
    logic [PW:0]   rd_gray;

    logic          mem_we;
    logic [PW-1:0] wr_addr;
    logic [PW:0]   wr_gray;
    logic          full;
    logic          afull;
    logic [PW:0]   level;
    logic          ovf;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    function automatic logic [PW:0] to_gray(input logic [PW:0] b);
        return b ^ (b >> 1);
    endfunction

    assign rd_gray = to_gray(rd_idx);

    wr_ptr_full_ctrl #(
        .PTR_W     (PW),
        .AF_MARGIN (AFM)
    ) dut (
        .i_wr_clk      (clk),
        .i_wr_rst      (rst),
        .i_wr_en       (wr_en),
        .i_rd_ptr_sync (rd_gray),
        .i_ovf_clr     (ovf_clr),
        .o_mem_we      (mem_we),
        .o_wr_addr     (wr_addr),
        .o_wr_ptr_gray (wr_gray),
        .o_full        (full),
        .o_almost_full (afull),
        .o_wr_level    (level),
        .o_overflow    (ovf)
    );

    always #5 clk = ~clk;

    // Reference model: count of accepted writes and occupancy against the driven read index.
    logic [PW:0] m_wcnt, m_level, m_gray, wn;
    logic        m_full, m_af, m_ovf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_wcnt  <= '0;
            m_level <= '0;
            m_gray  <= '0;
            m_full  <= 1'b0;
            m_af    <= 1'b0;
            m_ovf   <= 1'b0;
        end else begin
            wn = m_wcnt + ((wr_en && !m_full) ? 5'd1 : 5'd0);
            m_wcnt  <= wn;
            m_level <= wn - rd_idx;
            m_full  <= ((wn - rd_idx) == 5'd16);
            m_af    <= ((wn - rd_idx) >= 5'd14);
            m_gray  <= to_gray(wn);
            if (wr_en && m_full) m_ovf <= 1'b1;
            else if (ovf_clr)    m_ovf <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_mem_we", {31'd0, mem_we}, {31'd0, wr_en & ~m_full & ~rst});
            chk("m_addr",   {28'd0, wr_addr}, {28'd0, m_wcnt[PW-1:0]});
            chk("m_gray",   {27'd0, wr_gray}, {27'd0, m_gray});
            chk("m_full",   {31'd0, full},  {31'd0, m_full});
            chk("m_afull",  {31'd0, afull}, {31'd0, m_af});
            chk("m_level",  {27'd0, level}, {27'd0, m_level});
            chk("m_ovf",    {31'd0, ovf},   {31'd0, m_ovf});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise reset between edges and check outputs before any clock edge arrives.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr",   {28'd0, wr_addr}, 32'd0);
        chk("rst_gray",   {27'd0, wr_gray}, 32'd0);
        chk("rst_full",   {31'd0, full}, 32'd0);
        chk("rst_afull",  {31'd0, afull}, 32'd0);
        chk("rst_level",  {27'd0, level}, 32'd0);
        chk("rst_ovf",    {31'd0, ovf}, 32'd0);
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        rd_idx  = '0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    logic [PW:0] prev;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        chk("init_level", {27'd0, level}, 32'd0);
        chk("init_full",  {31'd0, full}, 32'd0);

        // Fill with the reader parked at 0.
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1;
            #1;
            chk("fill_addr", {28'd0, wr_addr}, i);
            step();
            if (i == 12) chk("fill_af_before", {31'd0, afull}, 32'd0);
            if (i == 13) chk("fill_af_at14",   {31'd0, afull}, 32'd1);
            if (i == 14) chk("fill_full_at15", {31'd0, full},  32'd0);
        end
        wr_en = 1'b0;
        chk("fill_full",  {31'd0, full}, 32'd1);
        chk("fill_level", {27'd0, level}, 32'd16);
        chk("fill_gray",  {27'd0, wr_gray}, 32'h18);

        // Overflow: rejected write, set beats clear, clear alone.
        wr_en = 1'b1;
        #1 chk("ovf_we_blocked", {31'd0, mem_we}, 32'd0);
        step();
        chk("ovf_set",       {31'd0, ovf}, 32'd1);
        chk("ovf_gray_hold", {27'd0, wr_gray}, 32'h18);
        chk("ovf_addr_hold", {28'd0, wr_addr}, 32'd0);
        ovf_clr = 1'b1;
        step();
        chk("ovf_set_wins", {31'd0, ovf}, 32'd1);
        wr_en = 1'b0;
        step();
        chk("ovf_cleared", {31'd0, ovf}, 32'd0);
        ovf_clr = 1'b0;

        // Release: reader advances by one; the write in that cycle is still refused.
        rd_idx = 5'd1;
        wr_en  = 1'b1;
        #1 chk("rel_same_cycle_reject", {31'd0, mem_we}, 32'd0);
        step();
        chk("rel_full",  {31'd0, full}, 32'd0);
        chk("rel_level", {27'd0, level}, 32'd15);
        #1;
        chk("rel_we",   {31'd0, mem_we}, 32'd1);
        chk("rel_addr", {28'd0, wr_addr}, 32'd0);
        step();
        wr_en = 1'b0;

        // Asynchronous reset with a pending write request.
        wr_en = 1'b1;
        do_reset();

        // Wrap: reader trails the writer by two writes.
        for (int k = 0; k < 40; k++) begin
            rd_idx = (k >= 2) ? 5'(k - 2) : 5'd0;
            wr_en  = 1'b1;
            prev   = wr_gray;
            step();
            chk("wrap_1bit", $countones(prev ^ wr_gray), 32'd1);
            chk("wrap_no_full", {31'd0, full}, 32'd0);
        end
        wr_en = 1'b0;
        chk("wrap_gray_end", {27'd0, wr_gray}, 32'h0C);

        // Mid-operation reset at level 9.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            wr_en = 1'b1;
            step();
        end
        wr_en = 1'b0;
        chk("mid_level9", {27'd0, level}, 32'd9);
        do_reset();
        wr_en = 1'b1;
        #1;
        chk("mid_first_we",   {31'd0, mem_we}, 32'd1);
        chk("mid_first_addr", {28'd0, wr_addr}, 32'd0);
        step();
        wr_en = 1'b0;
        step();
        chk("mid_level1", {27'd0, level}, 32'd1);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
